// File: rtl/def_pkg.sv
// ---------------------------------------------------------------------------
// def_pkg
// Shared definitions for the ALU core:
//   operation_t          3-bit opcode presented on the alu_core op port
//   MUL_LATENCY_DEFAULT  default accept-to-done latency of a multiply
// ---------------------------------------------------------------------------
package def_pkg;

    typedef enum logic [2:0] {
        no_op      = 3'b000,
        add_op     = 3'b001,
        and_op     = 3'b010,
        xor_op     = 3'b011,
        mul_op     = 3'b100,
        unused5_op = 3'b101,
        unused6_op = 3'b110,
        rst_op     = 3'b111
    } operation_t;

    localparam int MUL_LATENCY_DEFAULT = 3;

endpackage

// File: rtl/alu_mul_pipe.sv
// ---------------------------------------------------------------------------
// alu_mul_pipe
// 8x8 -> 16 unsigned multiplier, LATENCY register stages deep. The product
// of the operands sampled at edge N appears on product after edge
// N+LATENCY-1, i.e. it is stable in time for edge N+LATENCY to capture it.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears every stage
//   a, b     unsigned operands
//   product  registered full-width product
// ---------------------------------------------------------------------------
module alu_mul_pipe #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] product
);

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : gen_stage
            logic [15:0] q_reg;
            if (gi == 0) begin : gen_first
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= {8'h00, a} * {8'h00, b};
                    end
                end
            end else begin : gen_rest
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        q_reg <= '0;
                    end else begin
                        q_reg <= gen_stage[gi-1].q_reg;
                    end
                end
            end
        end
    endgenerate

    assign product = gen_stage[LATENCY-1].q_reg;

endmodule

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Single-command ALU with a start/done handshake. A command is accepted in
// IDLE on a rising edge with start=1; add/and/xor/no-op finish one edge
// later, multiply finishes MUL_LATENCY edges later, rst_op clears the result
// silently. After completion the FSM waits in RELEASE until start drops.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset (release is synchronised)
//   A, B     unsigned 8-bit operands
//   op       opcode (operation_t)
//   start    command request, held by requester until done is seen
//   done     one-cycle completion pulse
//   result   16-bit result, updated on the edge done rises
// ---------------------------------------------------------------------------
module alu_core
    import def_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  operation_t  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
);

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MUL,
        DONE,
        RELEASE
    } state_t;

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    state_t             state_reg;
    logic [7:0]         a_reg;
    logic [7:0]         b_reg;
    operation_t         op_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               done_reg;
    logic [15:0]        result_reg;
    logic [1:0]         sync_reg;
    logic               run;
    logic [15:0]        mul_product;

    // Reset release is passed through two flops so the FSM makes its first
    // move no earlier than the second edge after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign run = sync_reg[1];

    // The pipe samples the operand ports every cycle; only the product that
    // entered on the accept edge is still at the output when MUL captures it,
    // so later A/B changes have no effect on the command in flight.
    alu_mul_pipe #(
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (A),
        .b       (B),
        .product (mul_product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= no_op;
            cnt_reg    <= '0;
            done_reg   <= 1'b0;
            result_reg <= '0;
        end else if (run) begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_reg  <= A;
                        b_reg  <= B;
                        op_reg <= op;
                        if (op == mul_op) begin
                            cnt_reg   <= CNT_W'(MUL_LATENCY - 1);
                            state_reg <= MUL;
                        end else begin
                            state_reg <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    case (op_reg)
                        add_op: begin
                            result_reg <= {8'h00, a_reg} + {8'h00, b_reg};
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                        and_op: begin
                            result_reg <= {8'h00, a_reg & b_reg};
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                        xor_op: begin
                            result_reg <= {8'h00, a_reg ^ b_reg};
                            done_reg   <= 1'b1;
                            state_reg  <= DONE;
                        end
                        rst_op: begin
                            // Silent clear: no done pulse, straight to RELEASE.
                            result_reg <= '0;
                            state_reg  <= RELEASE;
                        end
                        default: begin
                            // no_op and unused codes complete without touching result.
                            done_reg  <= 1'b1;
                            state_reg <= DONE;
                        end
                    endcase
                end
                MUL: begin
                    if (cnt_reg == '0) begin
                        result_reg <= mul_product;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    // First RELEASE-like cycle: a requester that already
                    // dropped start goes straight back to IDLE.
                    done_reg  <= 1'b0;
                    state_reg <= start ? RELEASE : IDLE;
                end
                RELEASE: begin
                    if (!start) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign done   = done_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
    import def_pkg::*;

    localparam int MUL_LAT = 3;

    logic        clk;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    operation_t  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int total = 0;
    int bad = 0;
    int exp_done = 0;
    int done_seen = 0;
    logic [15:0] model_result = 16'h0000;

    alu_core #(
        .MUL_LATENCY (MUL_LAT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts cycles in which done is high; each command should contribute one.
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    // Reference behaviour straight from the opcode table.
    function automatic logic [15:0] ref_result(input operation_t o, input logic [7:0] a,
                                               input logic [7:0] b, input logic [15:0] prev);
        int unsigned ua, ub;
        ua = a;
        ub = b;
        case (o)
            add_op:  return 16'(ua + ub);
            and_op:  return 16'(ua & ub);
            xor_op:  return 16'(ua ^ ub);
            mul_op:  return 16'(ua * ub);
            rst_op:  return 16'h0000;
            default: return prev;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 with the
    // DUT back in IDLE, so consecutive calls exercise back-to-back accepts.
    task automatic run_cmd(input operation_t o, input logic [7:0] a, input logic [7:0] b,
                           input int hold, input bit early, input bit zero_scr);
        logic [15:0] prev;
        logic [15:0] expv;
        int lat;
        prev = model_result;
        expv = ref_result(o, a, b, prev);
        lat  = (o == mul_op) ? MUL_LAT : 1;
        A = a; B = b; op = o; start = 1'b1;
        @(posedge clk); #1;                       // just after accept edge T0
        chk("t0_no_done", {15'b0, done}, 16'h0000);
        chk("t0_result_hold", result, prev);
        if (zero_scr) begin
            A = 8'h00; B = 8'h00; op = no_op;
        end else begin
            A = 8'($urandom); B = 8'($urandom); op = operation_t'(3'($urandom_range(0, 7)));
        end
        if (early) start = 1'b0;
        for (int k = 1; k < lat; k++) begin
            @(posedge clk); #1;
            chk("early_no_done", {15'b0, done}, 16'h0000);
            chk("early_result_hold", result, prev);
        end
        @(posedge clk); #1;                       // just after T0+latency
        if (o == rst_op) begin
            chk("rst_no_done", {15'b0, done}, 16'h0000);
        end else begin
            chk("done_pulse", {15'b0, done}, 16'h0001);
            exp_done++;
        end
        chk("result", result, expv);
        model_result = expv;
        for (int k = 0; k < hold && !early; k++) begin
            @(posedge clk); #1;
            chk("held_no_done", {15'b0, done}, 16'h0000);
            chk("held_result", result, expv);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("release_no_done", {15'b0, done}, 16'h0000);
        chk("release_result", result, expv);
        $display("cmd op=%0d A=%02h B=%02h hold=%0d early=%0d result=%04h expected=%04h",
                 o, a, b, hold, early, result, expv);
    endtask

    initial begin
        bit seen;
        reset_n = 1'b0;
        start = 1'b0;
        A = 8'h00; B = 8'h00; op = no_op;

        // Reset state.
        #2;
        chk("reset_done", {15'b0, done}, 16'h0000);
        chk("reset_result", result, 16'h0000);

        // Reset release with start already high: no completion before the
        // third edge after release.
        repeat (2) @(posedge clk);
        #1;
        A = 8'h10; B = 8'h20; op = add_op; start = 1'b1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("sync_e1_no_done", {15'b0, done}, 16'h0000);
        @(posedge clk); #1;
        chk("sync_e2_no_done", {15'b0, done}, 16'h0000);
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk("sync_done_seen", {15'b0, seen}, 16'h0001);
        chk("sync_result", result, 16'h0030);
        exp_done++;
        model_result = 16'h0030;
        start = 1'b0;
        @(posedge clk); #1;
        chk("sync_release_no_done", {15'b0, done}, 16'h0000);
        $display("cmd reset-release add 10+20 result=%04h expected=0030", result);

        // Directed commands.
        run_cmd(add_op, 8'hFF, 8'h01, 3, 1'b0, 1'b0);     // carry, start held
        run_cmd(mul_op, 8'hFF, 8'hFF, 0, 1'b0, 1'b0);     // full-width product
        run_cmd(and_op, 8'hF0, 8'h3C, 0, 1'b0, 1'b0);
        run_cmd(xor_op, 8'hAA, 8'h55, 0, 1'b0, 1'b1);     // inputs zeroed after accept
        run_cmd(mul_op, 8'hFF, 8'hFF, 1, 1'b0, 1'b0);
        run_cmd(rst_op, 8'h12, 8'h34, 0, 1'b0, 1'b0);     // silent clear
        run_cmd(add_op, 8'h03, 8'h04, 0, 1'b0, 1'b0);
        run_cmd(no_op, 8'h55, 8'h66, 0, 1'b0, 1'b0);
        run_cmd(unused5_op, 8'h01, 8'h02, 2, 1'b0, 1'b0);
        run_cmd(unused6_op, 8'h03, 8'h04, 0, 1'b0, 1'b0);
        run_cmd(mul_op, 8'h0D, 8'h0B, 0, 1'b1, 1'b0);     // start dropped early
        run_cmd(rst_op, 8'h00, 8'h00, 2, 1'b0, 1'b0);

        // Reset during a multiply discards it.
        A = 8'd12; B = 8'd12; op = mul_op; start = 1'b1;
        @(posedge clk); #1;                       // T0
        @(posedge clk); #1;                       // T1
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        chk("midrst_done", {15'b0, done}, 16'h0000);
        chk("midrst_result", result, 16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_done_after", {15'b0, seen}, 16'h0000);
        chk("midrst_result_after", result, 16'h0000);
        model_result = 16'h0000;
        $display("cmd mid-mul reset result=%04h expected=0000", result);
        run_cmd(add_op, 8'h01, 8'h01, 0, 1'b0, 1'b0);

        // Random commands.
        for (int n = 0; n < 1000; n++) begin
            run_cmd(operation_t'(3'($urandom_range(0, 7))), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0), 1'b0);
        end

        total++;
        assert (done_seen === exp_done) else begin
            bad++;
            $error("FAIL done_count observed=%0d expected=%0d", done_seen, exp_done);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
